// File: rtl/wksg_event_logger.sv
// Event logger for the wksg sx/sy pair: registers the pair, detects changes and queues
// each change (new code + timestamp) in a small FIFO drained over valid/ready.
module wksg_event_logger #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sx,
  input  logic                     sy,
  input  logic                     clr,
  input  logic                     ev_ready,
  output logic                     ev_valid,
  output logic [1:0]               ev_code,
  output logic [TS_W-1:0]          ev_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [1:0]      s_r;
  logic [1:0]      prev_r;
  logic [TS_W-1:0] ts_r;
  logic [1:0]      code_mem_r [DEPTH];
  logic [TS_W-1:0] ts_mem_r   [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic            overflow_r;
  logic [CNT_W-1:0] drop_cnt_r;
  logic            illegal_r;

  logic change_s;
  logic pop_s;
  logic full_s;
  logic wr_en_s;
  logic drop_s;

  // Push/pop decisions; a full FIFO still accepts a push when the head pops on the same edge.
  always_comb begin
    change_s = 1'b0;
    pop_s    = 1'b0;
    full_s   = 1'b0;
    wr_en_s  = 1'b0;
    drop_s   = 1'b0;
    change_s = (s_r != prev_r);
    pop_s    = (level_r != {LW{1'b0}}) && ev_ready;
    full_s   = (level_r == LW'(DEPTH));
    wr_en_s  = change_s && (!full_s || pop_s);
    drop_s   = change_s && full_s && !pop_s;
  end

  // Sampling pipeline, timestamp, FIFO storage/pointers and sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r        <= 2'b00;
      prev_r     <= 2'b00;
      ts_r       <= {TS_W{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
      illegal_r  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        code_mem_r[i] <= 2'b00;
        ts_mem_r[i]   <= {TS_W{1'b0}};
      end
    end else if (clr) begin
      // A change pending in this cycle is discarded by resyncing prev to s.
      s_r        <= {sx, sy};
      prev_r     <= s_r;
      ts_r       <= {TS_W{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
      illegal_r  <= 1'b0;
    end else begin
      s_r    <= {sx, sy};
      prev_r <= s_r;
      ts_r   <= ts_r + TS_W'(1);
      if (s_r == 2'b11) begin
        illegal_r <= 1'b1;
      end
      if (wr_en_s) begin
        code_mem_r[wr_ptr_r] <= s_r;
        ts_mem_r[wr_ptr_r]   <= ts_r;
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != {CNT_W{1'b1}}) begin
          drop_cnt_r <= drop_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign ev_valid = (level_r != {LW{1'b0}});
  assign ev_code  = code_mem_r[rd_ptr_r];
  assign ev_ts    = ts_mem_r[rd_ptr_r];
  assign level    = level_r;
  assign overflow = overflow_r;
  assign drop_cnt = drop_cnt_r;
  assign illegal  = illegal_r;

endmodule

// File: tb/tb_wksg_event_logger.sv
// Randomized and directed bench for wksg_event_logger against a queue-based event model.
module tb_wksg_event_logger;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sx = 1'b0;
  logic       sy = 1'b0;
  logic       clr = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic [7:0] ev_ts;
  logic [2:0] level;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       illegal;

  always #5 clk = ~clk;

  wksg_event_logger #(.DEPTH(DEPTH), .TS_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sx(sx), .sy(sy), .clr(clr), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ts(ev_ts), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt), .illegal(illegal)
  );

  typedef struct packed {
    logic [1:0] code;
    logic [7:0] ts;
  } ev_t;

  ev_t        mq[$];
  logic [1:0] m_s, m_prev;
  logic [7:0] m_ts;
  logic       m_ovf, m_ill;
  int         m_drop;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_s = 2'b00; m_prev = 2'b00; m_ts = 8'd0;
    m_ovf = 1'b0; m_ill = 1'b0; m_drop = 0;
  endtask

  // One clock edge of the reference: events are the pair's changes, delayed by the sampling stage.
  task automatic model_step();
    bit pop, full, push;
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0; m_drop = 0; m_ill = 1'b0; m_ts = 8'd0;
      m_prev = m_s; m_s = {sx, sy};
    end else begin
      pop  = (mq.size() != 0) && ev_ready;
      full = (mq.size() == DEPTH);
      push = (m_s != m_prev);
      if (m_s == 2'b11) m_ill = 1'b1;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (!full || pop) mq.push_back(ev_t'({m_s, m_ts}));
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      m_prev = m_s; m_s = {sx, sy}; m_ts = m_ts + 8'd1;
    end
  endtask

  task automatic compare_all();
    check("ev_valid", ev_valid, mq.size() != 0);
    check("level", level, mq.size());
    check("overflow", overflow, m_ovf);
    check("drop_cnt", drop_cnt, m_drop);
    check("illegal", illegal, m_ill);
    if (mq.size() != 0) begin
      check("ev_code", ev_code, mq[0].code);
      check("ev_ts", ev_ts, mq[0].ts);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Called at a falling edge; asserts reset away from any clock edge and releases on the next fall.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid", ev_valid, 0);
    check("rst_level", level, 0);
    check("rst_flags", {overflow, illegal, drop_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_code;

    // Idle after reset
    do_reset();
    repeat (20) cyc();
    check("t1_valid", ev_valid, 0);
    check("t1_level", level, 0);
    check("t1_flags", {overflow, illegal, drop_cnt}, 0);

    // First event latency and timestamp
    do_reset();
    ev_ready = 1'b1;
    repeat (4) cyc();
    sx = 1'b1;
    cyc();
    cyc();
    check("t2_valid", ev_valid, 1);
    check("t2_code", ev_code, 2'b10);
    check("t2_ts", ev_ts, 5);
    cyc();
    check("t2_popped", ev_valid, 0);

    // Overflow with 6 toggles, then in-order drain
    sx = 1'b0; sy = 1'b0; ev_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sy = ~sy;
      cyc();
    end
    repeat (2) cyc();
    check("t3_level", level, 4);
    check("t3_ovf", overflow, 1);
    check("t3_drop", drop_cnt, 2);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_code = (i % 2 == 0) ? 2'b01 : 2'b00;
      check("t3_order", ev_code, exp_code);
      cyc();
    end
    check("t3_empty", level, 0);

    // Full FIFO with simultaneous push and pop
    ev_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sy = ~sy;
      cyc();
    end
    repeat (2) cyc();
    check("t4_full", level, 4);
    sy = ~sy;
    cyc();
    ev_ready = 1'b1;
    cyc();
    check("t4_level", level, 4);
    check("t4_drop", drop_cnt, 0);
    check("t4_ovf", overflow, 0);
    ev_ready = 1'b0;

    // Drop counter saturation
    do_reset();
    repeat (270) begin
      sy = ~sy;
      cyc();
    end
    repeat (2) cyc();
    check("sat_drop", drop_cnt, 255);
    check("sat_ovf", overflow, 1);

    // Illegal code and clear
    sx = 1'b0; sy = 1'b0;
    do_reset();
    cyc();
    sx = 1'b1; sy = 1'b1;
    cyc();
    sx = 1'b0; sy = 1'b0;
    repeat (3) cyc();
    check("t5_illegal", illegal, 1);
    check("t5_level", level, 2);
    check("t5_code", ev_code, 2'b11);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("t5_clr_ill", illegal, 0);
    check("t5_clr_lvl", level, 0);
    check("t5_clr_ovf", overflow, 0);
    sx = 1'b1;
    cyc();
    cyc();
    check("t5_ts_restart", ev_ts, 1);

    // Timestamp wrap, then reset mid-drain
    sx = 1'b0; sy = 1'b0;
    do_reset();
    repeat (289) cyc();
    sx = 1'b1;
    cyc();
    cyc();
    check("t6_wrap_ts", ev_ts, 34);
    check("t6_code", ev_code, 2'b10);
    sy = 1'b1; cyc();
    sy = 1'b0; repeat (3) cyc();
    ev_ready = 1'b1;
    cyc();
    do_reset();
    repeat (4) cyc();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) {sx, sy} = 2'($urandom_range(0, 3));
      ev_ready = ((i / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      cyc();
    end
    clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
